scsi_sd_sequencer: RTL and testbench
====================================

Name: scsi_sd_sequencer

Overview:
Sits between the SCSI controller's sector-request outputs (io_rd[1:0], io_wr[1:0], io_lba, io_ack) and the single-channel SD/io-controller port. It arbitrates the two target channels (index 1 = ID2, index 0 = ID6) and latches LBA and direction. It drives one sd_rd/sd_wr handshake toward the io controller, steers sd_ack back to the owning channel, and counts sector-buffer bytes to check every transfer for completeness.

Parameters:
SECTOR_BYTES, 512, bytes per sector; the byte counter width is clog2(SECTOR_BYTES)+1.
TIMEOUT_CYCLES, 24'd12000000, watchdog limit in clk cycles; used only with SD_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
io_rd  in  2  per-channel sector read request, level, held until acked
io_wr  in  2  per-channel sector write request, level
io_lba  in  32  LBA from the controller, valid while a request is high
io_ack  out  2  per-channel ack, copy of sd_ack routed to the owner
sd_rd  out  1  read request to io controller
sd_wr  out  1  write request to io controller
sd_lba  out  32  latched LBA
sd_drive  out  1  owning channel index
sd_ack  in  1  io controller busy/ack, level
sd_buff_wr  in  1  byte strobe into the sector buffer (read data)
sd_buff_addr  in  9  buffer address, used for write-side counting
busy  out  1  high whenever state is not IDLE
err  out  1  sticky error; cleared by reset or by the next grant

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE; sd_rd=0, sd_wr=0, sd_lba=0, sd_drive=0, io_ack=0, busy=0, err=0; counters=0, rr_last=0.
- All outputs are registered except io_ack, which is combinational: io_ack[sd_drive] = sd_ack & busy, the other bit = 0.
- States: IDLE, REQ, XFER, RELEASE.
- IDLE: pending[i] = io_rd[i] | io_wr[i].
  - Exactly one pending: grant it.
  - Both pending: grant the channel other than rr_last (round robin).
  - On grant, in one cycle: latch sd_lba=io_lba, sd_drive=i, dir=io_wr[i], rr_last=i; clear byte counter and err; go to REQ.
  - If io_rd[i] and io_wr[i] are both high, the read wins.
- REQ: sd_rd=~dir, sd_wr=dir, asserted on the cycle after the grant.
  - First cycle with sd_ack=1: drop sd_rd/sd_wr in the same edge, go to XFER.
- XFER: count bytes.
  - Read: count each clk with sd_buff_wr=1.
  - Write: count each change of sd_buff_addr.
  - The counter saturates at SECTOR_BYTES.
  - On sd_ack falling (registered previous value =1, current =0): if count != SECTOR_BYTES, set err; go to RELEASE.
- RELEASE: wait until io_rd[sd_drive] and io_wr[sd_drive] are both 0, then go to IDLE.
  - This prevents re-grant of a stale level request. Fairness lets the other channel win next.
- Glitches:
  - sd_ack going high in IDLE or RELEASE: ignored, no io_ack.
  - Requester dropping its request during REQ: the request to sd is still completed, and the result is discarded by the requester.
- Minimum latency: request high -> sd_rd high = 2 clk.
- sd_lba is stable from grant until the next grant.
- reset_n low in any state: immediate return to the reset values on that edge.

Optional Feature:
Macro SD_SEQ_TIMEOUT_EN.
- Defined: a 24-bit watchdog clears on entering REQ and counts in REQ and XFER.
  - On reaching TIMEOUT_CYCLES: drop sd_rd/sd_wr, set err, force io_ack[sd_drive] high for exactly 1 clk so the target unblocks, then go to RELEASE.
- Undefined: no watchdog, and REQ/XFER can wait forever.

Test Plan:
- Single read, ch1: io_rd=2'b10, io_lba=32'h0000_1234. Model acks after 5 clk and gives 512 sd_buff_wr strobes. Expect:
  - sd_rd high 2 clk after the request; sd_lba=1234, sd_drive=1.
  - io_ack=2'b10 mirrors sd_ack.
  - err=0; back to IDLE after io_rd drops.
- Simultaneous requests: io_rd=2'b01 and io_wr=2'b10 in the same cycle after reset (rr_last=0). Expect:
  - ch1 write first: sd_wr=1, sd_drive=1.
  - After completion and release, ch0 read: sd_rd=1, sd_drive=0.
- Short transfer: read with only 300 sd_buff_wr strobes before sd_ack falls -> err=1 after the fall; err clears on the next grant.
- Stale level: the requester holds io_rd=2'b01 for 10 clk after sd_ack falls -> no second sd_rd pulse until io_rd drops, then exactly one new grant when it rises again.
- Reset mid-XFER: reset_n low for 1 clk at byte 100 -> next cycle sd_rd=0, sd_wr=0, busy=0, err=0, io_ack=0.
- With SD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100: request issued, sd_ack never rises. Expect:
  - At cycle 100 of REQ: sd_rd drops and err=1.
  - io_ack[sd_drive] pulses for 1 clk, then RELEASE.

Source files
------------

// File: rtl/scsi_sd_sequencer_if.sv
// Bus bundle between the SCSI target channels, the sequencer and the SD/io controller.
// master = sequencer side, slave = the controller/target side facing it.
interface scsi_sd_sequencer_if;
   logic [1:0]  io_rd;
   logic [1:0]  io_wr;
   logic [31:0] io_lba;
   logic [1:0]  io_ack;
   logic        sd_rd;
   logic        sd_wr;
   logic [31:0] sd_lba;
   logic        sd_drive;
   logic        sd_ack;
   logic        sd_buff_wr;
   logic [8:0]  sd_buff_addr;
   logic        busy;
   logic        err;

   modport master (
      input  io_rd, io_wr, io_lba, sd_ack, sd_buff_wr, sd_buff_addr,
      output io_ack, sd_rd, sd_wr, sd_lba, sd_drive, busy, err
   );

   modport slave (
      output io_rd, io_wr, io_lba, sd_ack, sd_buff_wr, sd_buff_addr,
      input  io_ack, sd_rd, sd_wr, sd_lba, sd_drive, busy, err
   );
endinterface

// File: rtl/scsi_sd_sequencer.sv
// Two-channel SCSI sector request arbiter/sequencer toward a single SD port, with byte-count check.
// Optional watchdog enabled by defining SD_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner, arbitrate pending channels
// REQ     | sd_rd/sd_wr raised, waiting for sd_ack
// XFER    | sd_ack high, counting sector bytes until sd_ack falls
// RELEASE | wait for owner to drop its level request
module scsi_sd_sequencer #(
   parameter int          SECTOR_BYTES   = 512,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
   input logic                  clk,
   input logic                  reset_n,
   scsi_sd_sequencer_if.master  bus
);

   localparam int                CNT_W = $clog2(SECTOR_BYTES) + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(SECTOR_BYTES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_XFER    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              sd_rd_q, sd_rd_d;
   logic              sd_wr_q, sd_wr_d;
   logic [31:0]       sd_lba_q, sd_lba_d;
   logic              drive_q, drive_d;
   logic              dir_q, dir_d;
   logic              rr_last_q, rr_last_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sd_ack_q;
   logic [8:0]        addr_q;

   logic [1:0]        pend;
   logic              gnt;
   logic              step;
   logic              ack_win;
   logic              ack_bit;

`ifdef SD_SEQ_TIMEOUT_EN
   logic [23:0]       wd_q, wd_d;
   logic              to_pulse_q, to_pulse_d;
`else
   logic              unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         sd_rd_q   <= 1'b0;
         sd_wr_q   <= 1'b0;
         sd_lba_q  <= 32'd0;
         drive_q   <= 1'b0;
         dir_q     <= 1'b0;
         rr_last_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         sd_ack_q  <= 1'b0;
         addr_q    <= 9'd0;
`ifdef SD_SEQ_TIMEOUT_EN
         wd_q       <= 24'd0;
         to_pulse_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sd_rd_q   <= sd_rd_d;
         sd_wr_q   <= sd_wr_d;
         sd_lba_q  <= sd_lba_d;
         drive_q   <= drive_d;
         dir_q     <= dir_d;
         rr_last_q <= rr_last_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         sd_ack_q  <= bus.sd_ack;
         addr_q    <= bus.sd_buff_addr;
`ifdef SD_SEQ_TIMEOUT_EN
         wd_q       <= wd_d;
         to_pulse_q <= to_pulse_d;
`endif
      end
   end

   // Round robin only matters when both channels are pending.
   always_comb begin
      pend = bus.io_rd | bus.io_wr;
      gnt  = 1'b0;
      if (pend == 2'b11) begin
         gnt = ~rr_last_q;
      end else if (pend[1]) begin
         gnt = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      sd_rd_d   = sd_rd_q;
      sd_wr_d   = sd_wr_q;
      sd_lba_d  = sd_lba_q;
      drive_d   = drive_q;
      dir_d     = dir_q;
      rr_last_d = rr_last_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      step      = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
      wd_d       = wd_q;
      to_pulse_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (|pend) begin
               state_d   = S_REQ;
               sd_lba_d  = bus.io_lba;
               drive_d   = gnt;
               dir_d     = bus.io_wr[gnt] & ~bus.io_rd[gnt];
               rr_last_d = gnt;
               cnt_d     = '0;
               err_d     = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
               wd_d      = 24'd0;
`endif
            end
         end

         S_REQ: begin
            if (bus.sd_ack) begin
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
               state_d = S_XFER;
            end else begin
               sd_rd_d = ~dir_q;
               sd_wr_d = dir_q;
            end
         end

         S_XFER: begin
            // Reads are counted by buffer strobes, writes by the controller walking the address.
            step = dir_q ? (bus.sd_buff_addr != addr_q) : bus.sd_buff_wr;
            if (step && (cnt_q != FULL)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (sd_ack_q && !bus.sd_ack) begin
               if (cnt_d != FULL) begin
                  err_d = 1'b1;
               end
               state_d = S_RELEASE;
            end
         end

         S_RELEASE: begin
            if (!bus.io_rd[drive_q] && !bus.io_wr[drive_q]) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef SD_SEQ_TIMEOUT_EN
      if ((state_q == S_REQ) || (state_q == S_XFER)) begin
         wd_d = wd_q + 24'd1;
         if (wd_q == (TIMEOUT_CYCLES - 24'd1)) begin
            sd_rd_d    = 1'b0;
            sd_wr_d    = 1'b0;
            err_d      = 1'b1;
            to_pulse_d = 1'b1;
            state_d    = S_RELEASE;
         end
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   // Ack is only forwarded while a transfer is actually owned; stray acks in IDLE/RELEASE are dropped.
   always_comb begin
      ack_win = ((state_q == S_REQ) || (state_q == S_XFER)) & bus.sd_ack & busy_q;
`ifdef SD_SEQ_TIMEOUT_EN
      ack_bit = ack_win | to_pulse_q;
`else
      ack_bit = ack_win;
`endif
      bus.io_ack = drive_q ? {ack_bit, 1'b0} : {1'b0, ack_bit};
   end

   assign bus.sd_rd    = sd_rd_q;
   assign bus.sd_wr    = sd_wr_q;
   assign bus.sd_lba   = sd_lba_q;
   assign bus.sd_drive = drive_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_scsi_sd_sequencer.sv
// Directed bench for scsi_sd_sequencer: arbitration, latency, byte-count check, stale requests, reset.
module tb_scsi_sd_sequencer;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_fail;

   scsi_sd_sequencer_if bus ();

   scsi_sd_sequencer #(
      .SECTOR_BYTES   (512),
      .TIMEOUT_CYCLES (24'd12000000)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_req(input string tag, input logic exp_wr, input logic exp_drive);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (bus.sd_rd || bus.sd_wr) seen = 1'b1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_rd"}, 32'(bus.sd_rd), 32'(!exp_wr));
      chk({tag, "_wr"}, 32'(bus.sd_wr), 32'(exp_wr));
      chk({tag, "_drive"}, 32'(bus.sd_drive), 32'(exp_drive));
   endtask

   // Raise sd_ack, move nbytes, drop sd_ack; returns with the DUT in RELEASE.
   task automatic serve(input string tag, input int nbytes, input logic wr, input logic [1:0] exp_ack);
      bus.sd_ack = 1'b1;
      #1;
      chk({tag, "_ioack_hi"}, 32'(bus.io_ack), 32'(exp_ack));
      tick();
      chk({tag, "_req_drop"}, 32'(bus.sd_rd | bus.sd_wr), 32'd0);
      for (int i = 0; i < nbytes; i++) begin
         if (wr) bus.sd_buff_addr = bus.sd_buff_addr + 9'd1;
         else    bus.sd_buff_wr   = 1'b1;
         tick();
      end
      bus.sd_buff_wr = 1'b0;
      bus.sd_ack     = 1'b0;
      #1;
      chk({tag, "_ioack_lo"}, 32'(bus.io_ack), 32'd0);
      tick();
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL global_timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "bench timeout");
   end

   initial begin
      int stale_hits;
      n_chk            = 0;
      n_fail           = 0;
      reset_n          = 1'b0;
      bus.io_rd        = 2'b00;
      bus.io_wr        = 2'b00;
      bus.io_lba       = 32'd0;
      bus.sd_ack       = 1'b0;
      bus.sd_buff_wr   = 1'b0;
      bus.sd_buff_addr = 9'd0;
      tick();
      do_reset();
      tick();

      // Reset values
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("rst_lba", bus.sd_lba, 32'd0);
      chk("rst_drive", 32'(bus.sd_drive), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_ioack", 32'(bus.io_ack), 32'd0);

      // Stray ack while idle
      bus.sd_ack = 1'b1;
      #1;
      chk("idle_glitch_ioack", 32'(bus.io_ack), 32'd0);
      tick();
      chk("idle_glitch_busy", 32'(bus.busy), 32'd0);
      bus.sd_ack = 1'b0;
      tick();

      // Single read on ch1, 2-cycle latency
      bus.io_rd  = 2'b10;
      bus.io_lba = 32'h0000_1234;
      tick();
      chk("t1_sdrd_c1", 32'(bus.sd_rd), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_lba", bus.sd_lba, 32'h0000_1234);
      chk("t1_drive", 32'(bus.sd_drive), 32'd1);
      tick();
      chk("t1_sdrd_c2", 32'(bus.sd_rd), 32'd1);
      chk("t1_sdwr_c2", 32'(bus.sd_wr), 32'd0);
      tick();
      tick();
      tick();
      chk("t1_sdrd_hold", 32'(bus.sd_rd), 32'd1);
      serve("t1", 512, 1'b0, 2'b10);
      chk("t1_err", 32'(bus.err), 32'd0);
      chk("t1_release_busy", 32'(bus.busy), 32'd1);
      bus.io_rd = 2'b00;
      tick();
      chk("t1_idle", 32'(bus.busy), 32'd0);

      // Simultaneous ch0 read / ch1 write right after reset
      do_reset();
      tick();
      bus.io_rd  = 2'b01;
      bus.io_wr  = 2'b10;
      bus.io_lba = 32'hAAAA_0001;
      wait_req("t2a", 1'b1, 1'b1);
      bus.io_lba = 32'h5555_0002;
      tick();
      chk("t2a_lba_stable", bus.sd_lba, 32'hAAAA_0001);
      serve("t2a", 512, 1'b1, 2'b10);
      chk("t2a_err", 32'(bus.err), 32'd0);
      bus.io_wr = 2'b00;
      wait_req("t2b", 1'b0, 1'b0);
      chk("t2b_lba", bus.sd_lba, 32'h5555_0002);
      serve("t2b", 512, 1'b0, 2'b01);
      chk("t2b_err", 32'(bus.err), 32'd0);
      bus.io_rd = 2'b00;
      tick();
      tick();

      // Short read: 300 bytes
      bus.io_rd  = 2'b01;
      bus.io_lba = 32'h0000_0300;
      wait_req("t3", 1'b0, 1'b0);
      serve("t3", 300, 1'b0, 2'b01);
      chk("t3_err_set", 32'(bus.err), 32'd1);
      bus.io_rd = 2'b00;
      tick();
      tick();
      chk("t3_err_sticky", 32'(bus.err), 32'd1);
      chk("t3_idle", 32'(bus.busy), 32'd0);

      // Next grant clears err; then stale level held after completion
      bus.io_rd = 2'b01;
      tick();
      chk("t4_err_clr", 32'(bus.err), 32'd0);
      wait_req("t4a", 1'b0, 1'b0);
      serve("t4a", 512, 1'b0, 2'b01);
      stale_hits = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.sd_rd || bus.sd_wr || !bus.busy) stale_hits++;
         tick();
      end
      chk("t4_stale_no_req", 32'(stale_hits), 32'd0);
      bus.io_rd = 2'b00;
      tick();
      tick();
      chk("t4_idle", 32'(bus.busy), 32'd0);
      bus.io_rd = 2'b01;
      wait_req("t4b", 1'b0, 1'b0);
      serve("t4b", 512, 1'b0, 2'b01);
      chk("t4b_err", 32'(bus.err), 32'd0);
      bus.io_rd = 2'b00;
      tick();
      tick();

      // Reset in the middle of a write transfer
      bus.io_wr  = 2'b10;
      bus.io_lba = 32'h0000_0777;
      wait_req("t5", 1'b1, 1'b1);
      bus.sd_ack = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         bus.sd_buff_addr = bus.sd_buff_addr + 9'd1;
         tick();
      end
      chk("t5_busy_pre", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      tick();
      chk("t5_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("t5_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_err", 32'(bus.err), 32'd0);
      chk("t5_ioack", 32'(bus.io_ack), 32'd0);
      chk("t5_lba", bus.sd_lba, 32'd0);
      reset_n    = 1'b1;
      bus.io_wr  = 2'b00;
      bus.sd_ack = 1'b0;
      tick();
      tick();
      chk("t5_idle", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
